// File: rtl/neopixel_driver_if.sv
// Host-side bus of the NeoPixel driver: pixel writes, frame start, ready and the serial line.
// Handshake: load and go are sampled on every rising clock edge but take effect only while ready=1;
// there is no per-transfer acknowledge, and ready=0 means both strobes are dropped silently.
interface neopixel_driver_if;
  logic [2:0] pixel;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic       load;
  logic       go;
  logic       ready;
  logic       neo_data;

  modport master (
    output pixel, red, green, blue, load, go,
    input  ready, neo_data
  );

  modport slave (
    input  pixel, red, green, blue, load, go,
    output ready, neo_data
  );
endinterface

// File: rtl/neopixel_driver.sv
// WS2812-class serial driver: 8-entry GRB frame buffer streamed as pulse-width-encoded NRZ bits,
// followed by a low latch period.
module neopixel_driver #(
  parameter int CLK_PER_BIT  = 63,
  parameter int T0H          = 18,
  parameter int T1H          = 35,
  parameter int LATCH_CYCLES = 2500,
  parameter int NUM_PX       = 8
) (
  input  logic              clock,
  input  logic              reset,
  neopixel_driver_if.slave  bus,
  output logic [1:0]        state_dbg
);

  localparam int CMAX = (LATCH_CYCLES > CLK_PER_BIT) ? LATCH_CYCLES : CLK_PER_BIT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int PW   = (NUM_PX > 1) ? $clog2(NUM_PX) : 1;

  localparam logic [CW-1:0] T0_LAST    = CW'(T0H - 1);
  localparam logic [CW-1:0] T1_LAST    = CW'(T1H - 1);
  localparam logic [CW-1:0] BIT_LAST   = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);
  localparam logic [PW-1:0] PX_LAST    = PW'(NUM_PX - 1);
  localparam logic [4:0]    BIT_MSB    = 5'd23;

  generate
    if (!((T0H < T1H) && (T1H < CLK_PER_BIT))) begin : g_bad_timing
      $error("neopixel_driver: require T0H < T1H < CLK_PER_BIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    LATCH = 2'd3
  } state_t;

  state_t        state;
  logic [PW-1:0] px_ct;
  logic [4:0]    bit_ct;
  logic [CW-1:0] cyc_ct;
  logic [23:0]   buffer [NUM_PX];

  logic          cur_bit;
  logic [CW-1:0] high_last;

  // Buffer cannot change mid-frame, so the selected bit is stable for the whole bit period.
  assign cur_bit   = buffer[px_ct][BIT_MSB - bit_ct];
  assign high_last = cur_bit ? T1_LAST : T0_LAST;

  assign bus.ready = (state == IDLE);
  assign state_dbg = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      px_ct        <= '0;
      bit_ct       <= '0;
      cyc_ct       <= '0;
      bus.neo_data <= 1'b0;
      for (int i = 0; i < NUM_PX; i++) begin
        buffer[i] <= 24'h000000;
      end
    end else begin
      case (state)
        IDLE: begin
          bus.neo_data <= 1'b0;
          if (bus.load) begin
            buffer[bus.pixel] <= {bus.green, bus.red, bus.blue};
          end
          if (bus.go) begin
            state        <= HIGH;
            px_ct        <= '0;
            bit_ct       <= '0;
            cyc_ct       <= '0;
            bus.neo_data <= 1'b1;
          end
        end

        HIGH: begin
          // cyc_ct keeps running through the low part so the bit period is one count.
          cyc_ct <= cyc_ct + 1'b1;
          if (cyc_ct == high_last) begin
            state        <= LOW;
            bus.neo_data <= 1'b0;
          end
        end

        LOW: begin
          if (cyc_ct == BIT_LAST) begin
            cyc_ct <= '0;
            if (bit_ct < BIT_MSB) begin
              bit_ct       <= bit_ct + 1'b1;
              state        <= HIGH;
              bus.neo_data <= 1'b1;
            end else if (px_ct < PX_LAST) begin
              bit_ct       <= '0;
              px_ct        <= px_ct + 1'b1;
              state        <= HIGH;
              bus.neo_data <= 1'b1;
            end else begin
              state        <= LATCH;
              bus.neo_data <= 1'b0;
            end
          end else begin
            cyc_ct <= cyc_ct + 1'b1;
          end
        end

        LATCH: begin
          bus.neo_data <= 1'b0;
          if (cyc_ct == LATCH_LAST) begin
            cyc_ct <= '0;
            state  <= IDLE;
          end else begin
            cyc_ct <= cyc_ct + 1'b1;
          end
        end

        default: begin
          state        <= IDLE;
          bus.neo_data <= 1'b0;
        end
      endcase
    end
  end

endmodule
